// File: rtl/mem_responder.sv
// Word-organised memory responder with a fixed wait-state count.
// One request at a time: accept in IDLE, count wait states, complete
// with a one-cycle mem_data_ready pulse, then hold until the initiator
// releases mem_addr_ready. Loads are lane-extracted and extended;
// stores are merged into the addressed word.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | no request in flight; accepts a new request
// WAIT   | wait states remaining in counter
// DONE   | completion cycle; store commits on the exit edge
// HOLD   | completion issued; wait for mem_addr_ready to drop
module mem_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] bus,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_size,
  input  logic        mem_addr_ready,
  output logic        mem_data_ready,
  output logic [31:0] mem_rdata,
  output logic        mem_rdata_en,
  output logic        mem_err,
  output logic        busy
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [3:0]  WS      = 4'(WAIT_STATES);
  localparam logic [29:0] DEPTH_W = 30'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic [3:0]  cnt_nxt;

  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [3:0]  req_size;
  logic        req_is_read;
  logic        req_is_write;

  logic [31:0] mem [DEPTH];

  logic        accept;
  logic [29:0] word_idx;
  logic [AW-1:0] mem_idx;
  logic        in_range;
  logic [31:0] cur_word;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_val;
  logic [31:0] store_word;
  logic        done_ok;
  logic        commit;

  logic        ready_nxt;
  logic        err_nxt;
  logic        rdata_en_nxt;
  logic [31:0] rdata_nxt;
  logic        busy_nxt;

  assign accept   = (state == S_IDLE) && mem_addr_ready && (mem_read || mem_write);
  assign word_idx = req_addr[31:2];
  assign mem_idx  = word_idx[AW-1:0];
  assign in_range = (word_idx < DEPTH_W);
  assign cur_word = mem[mem_idx];
  assign done_ok  = (state == S_DONE) && mem_addr_ready;
  assign commit   = done_ok && req_is_write && in_range && !reset;

  // State and wait counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and counter decode
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_nxt = S_DONE;
            cnt_nxt   = 4'd0;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = WS;
          end
        end
      end
      S_WAIT: begin
        if (!mem_addr_ready) begin
          state_nxt = S_IDLE;
          cnt_nxt   = 4'd0;
        end else if (cnt <= 4'd1) begin
          state_nxt = S_DONE;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_DONE: begin
        // an initiator that has already let go gets no completion
        state_nxt = mem_addr_ready ? S_HOLD : S_IDLE;
      end
      S_HOLD: begin
        if (!mem_addr_ready) state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Request capture on accept; read wins when both op bits are set
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_addr     <= 32'd0;
      req_data     <= 32'd0;
      req_size     <= 4'd0;
      req_is_read  <= 1'b0;
      req_is_write <= 1'b0;
    end else if (accept) begin
      req_addr     <= addr;
      req_data     <= bus;
      req_size     <= mem_size;
      req_is_read  <= mem_read;
      req_is_write <= mem_write && !mem_read;
    end
  end

  // Lane selection and load extension
  always_comb begin
    lane_byte = 8'd0;
    lane_half = req_addr[1] ? cur_word[31:16] : cur_word[15:0];
    case (req_addr[1:0])
      2'd0:    lane_byte = cur_word[7:0];
      2'd1:    lane_byte = cur_word[15:8];
      2'd2:    lane_byte = cur_word[23:16];
      default: lane_byte = cur_word[31:24];
    endcase

    load_val = cur_word;
    if (req_size[3])      load_val = {{24{lane_byte[7]}}, lane_byte};
    else if (req_size[2]) load_val = {24'd0, lane_byte};
    else if (req_size[1]) load_val = {{16{lane_half[15]}}, lane_half};
    else if (req_size[0]) load_val = {16'd0, lane_half};
    if (!in_range) load_val = 32'd0;
  end

  // Store merge: only the addressed lane changes
  always_comb begin
    store_word = cur_word;
    if (req_size[3]) begin
      case (req_addr[1:0])
        2'd0:    store_word[7:0]   = req_data[7:0];
        2'd1:    store_word[15:8]  = req_data[7:0];
        2'd2:    store_word[23:16] = req_data[7:0];
        default: store_word[31:24] = req_data[7:0];
      endcase
    end else if (req_size[1]) begin
      if (req_addr[1]) store_word[31:16] = req_data[15:0];
      else             store_word[15:0]  = req_data[15:0];
    end else begin
      store_word = req_data;
    end
  end

  // Storage write; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (commit) mem[mem_idx] <= store_word;
  end

  // Output decode: values that the output registers take on the next edge
  always_comb begin
    ready_nxt    = done_ok;
    err_nxt      = done_ok && !in_range;
    rdata_en_nxt = done_ok && req_is_read;
    rdata_nxt    = rdata_en_nxt ? load_val : 32'd0;
    busy_nxt     = (state_nxt != S_IDLE);
  end

  // Registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_data_ready <= 1'b0;
      mem_rdata      <= 32'd0;
      mem_rdata_en   <= 1'b0;
      mem_err        <= 1'b0;
      busy           <= 1'b0;
    end else begin
      mem_data_ready <= ready_nxt;
      mem_rdata      <= rdata_nxt;
      mem_rdata_en   <= rdata_en_nxt;
      mem_err        <= err_nxt;
      busy           <= busy_nxt;
    end
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH, default 1024: word-addressed storage depth (power of two, 16..65536).
REQ-002 Parameter WAIT_STATES, default 1: cycles inserted between accept and completion, range 0..15.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 addr  input  32  byte address of the request.
REQ-006 bus  input  32  store data, right-aligned.
REQ-007 mem_read  input  1  request is a load.
REQ-008 mem_write  input  1  request is a store.
REQ-009 mem_size  input  4  one-hot {signed byte, unsigned byte, signed half, unsigned half}; 0000 = word; stores use bit3 = byte, bit1 = half.
REQ-010 mem_addr_ready  input  1  initiator asserts that addr/size/data are stable.
REQ-011 mem_data_ready  output  1  one-cycle completion pulse.
REQ-012 mem_rdata  output  32  extended load data, valid only while mem_data_ready.
REQ-013 mem_rdata_en  output  1  drive enable for mem_rdata onto the shared bus; high only on load completion.
REQ-014 mem_err  output  1  one-cycle pulse with mem_data_ready when the access is out of range.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 FSM states: IDLE, WAIT, DONE, HOLD; all outputs registered.
REQ-017 IDLE: mem_addr_ready && (mem_read || mem_write) accepts; latches addr, bus, mem_size and op; goes to WAIT with counter = WAIT_STATES, or to DONE directly when WAIT_STATES = 0.
REQ-018 mem_read && mem_write both high at accept: treated as a read; no write occurs.
REQ-019 WAIT: counter decrements each cycle; at 1 go to DONE; latency from accept edge to mem_data_ready high = WAIT_STATES + 1 cycles.
REQ-020 WAIT or DONE entry with mem_addr_ready low (initiator abort/trap): return to IDLE, no write, no mem_data_ready.
REQ-021 DONE: mem_data_ready = 1 for exactly one cycle; store committed on this cycle's exit edge; then go to HOLD.
REQ-022 HOLD: stays until mem_addr_ready = 0, then IDLE; a request is never accepted in the cycle after DONE.
REQ-023 Word index = latched addr[31:2]; addr[1:0] selects the byte lane, addr[1] the half lane; word access ignores addr[1:0].
REQ-024 Loads: byte/half extracted from the lane, sign-extended (bit3/bit1) or zero-extended (bit2/bit0); word returned unchanged.
REQ-025 Stores: byte writes bus[7:0] into lane addr[1:0]; half writes bus[15:0] into lane addr[1]; other bytes preserved.
REQ-026 Index >= DEPTH: load returns 0x00000000, store dropped, mem_err pulses with mem_data_ready.
REQ-027 mem_rdata = 0 and mem_rdata_en = 0 whenever mem_data_ready = 0 or the op is a store.
REQ-028 Storage contents are undefined at power-up and are not cleared by reset.

Reset
REQ-029 reset asserted: state = IDLE, counter = 0, mem_data_ready = 0, mem_rdata = 0, mem_rdata_en = 0, mem_err = 0, busy = 0, all asynchronously.
REQ-030 reset mid-WAIT or DONE: pending store discarded; no partial write; first accept possible on the first posedge after reset deasserts.

Verification
REQ-031 WAIT_STATES=1: word store 0xDEADBEEF to 0x10, then word load from 0x10 -> mem_data_ready 2 cycles after each accept, rdata 0xDEADBEEF, mem_rdata_en high only on the load.
REQ-032 Byte store 0x80 to 0x13 over word 0x11223344 -> word reads 0x80223344; signed-byte load of 0x13 -> 0xFFFFFF80; unsigned-byte load -> 0x00000080.
REQ-033 Signed-half load from 0x12 holding 0x8001 -> 0xFFFF8001; unsigned-half load -> 0x00008001.
REQ-034 Store to 0x00001000 with DEPTH=1024 -> mem_err pulses with mem_data_ready; a subsequent word load of index 0 is unchanged.
REQ-035 mem_addr_ready dropped during WAIT of a store (WAIT_STATES=3) -> no mem_data_ready, memory unchanged, busy low next cycle.
REQ-036 mem_addr_ready held high after DONE -> state stays HOLD, no second access, until mem_addr_ready goes low.
